// File: rtl/drawing_canvas_layered_if.sv
// Write, clear-control and compositor-read signals of the layered canvas.
// The master side drives requests and addresses; the slave side is the canvas.
interface drawing_canvas_layered_if #(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int LAYERS      = 2,
  parameter int COLOR_WIDTH = 8
);
  localparam int LW = (LAYERS > 1) ? $clog2(LAYERS) : 1;
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  logic                          wr_valid;
  logic                          wr_ready;
  logic [LW-1:0]                 wr_layer;
  logic [XW-1:0]                 wr_x;
  logic [YW-1:0]                 wr_y;
  logic [COLOR_WIDTH-1:0]        wr_color;
  logic                          clr_valid;
  logic                          clr_ready;
  logic                          clr_all;
  logic [LW-1:0]                 clr_layer;
  logic                          busy;
  logic [XW-1:0]                 rd_x;
  logic [YW-1:0]                 rd_y;
  logic [LAYERS*COLOR_WIDTH-1:0] rd_layers;
  logic [COLOR_WIDTH-1:0]        rd_color;

  modport master (
    output wr_valid, wr_layer, wr_x, wr_y, wr_color,
    output clr_valid, clr_all, clr_layer, rd_x, rd_y,
    input  wr_ready, clr_ready, busy, rd_layers, rd_color
  );

  modport slave (
    input  wr_valid, wr_layer, wr_x, wr_y, wr_color,
    input  clr_valid, clr_all, clr_layer, rd_x, rd_y,
    output wr_ready, clr_ready, busy, rd_layers, rd_color
  );
endinterface

// File: rtl/drawing_canvas_layered.sv
// Layered pixel store: per-layer colour planes, handshake writes, an FSM bulk clear
// and a registered read port that also composites the top-most opaque colour.
module drawing_canvas_layered #(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int LAYERS      = 2,
  parameter int COLOR_WIDTH = 8,
  parameter logic [COLOR_WIDTH-1:0] COLOR_NONE = {COLOR_WIDTH{1'b0}}
) (
  input logic                     clk,
  input logic                     reset_n,
  drawing_canvas_layered_if.slave bus
);
  localparam int LW    = (LAYERS > 1) ? $clog2(LAYERS) : 1;
  localparam int XW    = $clog2(WIDTH);
  localparam int YW    = $clog2(HEIGHT);
  localparam int DEPTH = WIDTH * HEIGHT;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = COLOR_WIDTH;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t               state_r, state_nxt_s;
  logic [AW-1:0]        cnt_r, cnt_nxt_s;
  logic                 clr_all_r, clr_all_nxt_s;
  logic [LW-1:0]        clr_layer_r, clr_layer_nxt_s;
  logic                 wr_ready_s, clr_ready_s, busy_s, sweep_s;
  logic                 wr_fire_s, rd_in_range_s;
  logic [AW-1:0]        wr_addr_s, rd_addr_s;
  logic [CW-1:0]        mem_r [LAYERS][DEPTH];
  logic [LAYERS*CW-1:0] rd_layers_r;
  logic [CW-1:0]        rd_color_s;

  function automatic logic [AW-1:0] pix_addr(input logic [XW-1:0] x, input logic [YW-1:0] y);
    logic [31:0] a_v;
    a_v = 32'(y) * 32'(WIDTH) + 32'(x);
    return a_v[AW-1:0];
  endfunction

  function automatic logic pix_in_range(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return (32'(x) < 32'(WIDTH)) && (32'(y) < 32'(HEIGHT));
  endfunction

  assign wr_addr_s     = pix_addr(bus.wr_x, bus.wr_y);
  assign rd_addr_s     = pix_addr(bus.rd_x, bus.rd_y);
  assign rd_in_range_s = pix_in_range(bus.rd_x, bus.rd_y);
  // Out-of-range writes still complete the handshake; they just never reach memory.
  assign wr_fire_s     = bus.wr_valid && wr_ready_s && pix_in_range(bus.wr_x, bus.wr_y)
                         && (32'(bus.wr_layer) < 32'(LAYERS));

  // FSM state and latched clear request; reset starts a full all-layer sweep.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_CLEAR;
      cnt_r       <= {AW{1'b0}};
      clr_all_r   <= 1'b1;
      clr_layer_r <= {LW{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      clr_all_r   <= clr_all_nxt_s;
      clr_layer_r <= clr_layer_nxt_s;
    end
  end

  // Next-state and handshake decode; a pending clear blocks writes in IDLE.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    clr_all_nxt_s   = clr_all_r;
    clr_layer_nxt_s = clr_layer_r;
    wr_ready_s      = 1'b0;
    clr_ready_s     = 1'b0;
    busy_s          = 1'b0;
    sweep_s         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        wr_ready_s  = !bus.clr_valid;
        clr_ready_s = 1'b1;
        if (bus.clr_valid) begin
          state_nxt_s     = ST_CLEAR;
          cnt_nxt_s       = {AW{1'b0}};
          clr_all_nxt_s   = bus.clr_all;
          clr_layer_nxt_s = bus.clr_layer;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        busy_s  = 1'b1;
        sweep_s = 1'b1;
        if (cnt_r == LAST_ADDR) begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = {AW{1'b0}};
        end else begin
          cnt_nxt_s = cnt_r + AW'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Pixel planes: the sweep clears the selected layer(s), otherwise an accepted write lands.
  always_ff @(posedge clk) begin
    for (int l = 0; l < LAYERS; l++) begin
      if (sweep_s && (clr_all_r || (32'(clr_layer_r) == 32'(l)))) begin
        mem_r[l][cnt_r] <= COLOR_NONE;
      end else if (wr_fire_s && (32'(bus.wr_layer) == 32'(l))) begin
        mem_r[l][wr_addr_s] <= bus.wr_color;
      end
    end
  end

  // Registered read of every layer; old data is returned on a same-cycle write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_layers_r <= {LAYERS{COLOR_NONE}};
    end else begin
      for (int l = 0; l < LAYERS; l++) begin
        rd_layers_r[l*CW +: CW] <= rd_in_range_s ? mem_r[l][rd_addr_s] : COLOR_NONE;
      end
    end
  end

  // Composite: later (higher) opaque layers override lower ones.
  always_comb begin
    rd_color_s = COLOR_NONE;
    for (int l = 0; l < LAYERS; l++) begin
      if (rd_layers_r[l*CW +: CW] != COLOR_NONE) begin
        rd_color_s = rd_layers_r[l*CW +: CW];
      end else begin
        rd_color_s = rd_color_s;
      end
    end
  end

  assign bus.wr_ready  = wr_ready_s;
  assign bus.clr_ready = clr_ready_s;
  assign bus.busy      = busy_s;
  assign bus.rd_layers = rd_layers_r;
  assign bus.rd_color  = rd_color_s;
endmodule

// File: tb/tb_drawing_canvas_layered.sv
// Randomised self-checking bench: an 8x8x2 canvas for the main scenarios plus a
// 10x6x3 canvas whose wider buses reach out-of-range coordinates and layers.
module tb_drawing_canvas_layered;
  localparam logic [7:0] C_NONE  = 8'h00;
  localparam logic [7:0] C_BLUE  = 8'h03;
  localparam logic [7:0] C_RED   = 8'he0;
  localparam logic [7:0] C_GREEN = 8'h1c;

  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [7:0] ma [2][8][8];
  logic [7:0] mb [3][6][10];

  always #5 clk = ~clk;

  drawing_canvas_layered_if #(.WIDTH(8), .HEIGHT(8), .LAYERS(2), .COLOR_WIDTH(8)) bus_a ();
  drawing_canvas_layered_if #(.WIDTH(10), .HEIGHT(6), .LAYERS(3), .COLOR_WIDTH(8)) bus_b ();

  drawing_canvas_layered #(.WIDTH(8), .HEIGHT(8), .LAYERS(2), .COLOR_WIDTH(8), .COLOR_NONE(8'h00))
    dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));
  drawing_canvas_layered #(.WIDTH(10), .HEIGHT(6), .LAYERS(3), .COLOR_WIDTH(8), .COLOR_NONE(8'h00))
    dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rand_color();
    logic [7:0] c;
    c = ($urandom_range(3, 0) == 0) ? C_NONE : 8'($urandom_range(255, 1));
    return c;
  endfunction

  function automatic logic [7:0] comp_a(input int x, input int y);
    for (int l = 1; l >= 0; l--) begin
      if (ma[l][y][x] != C_NONE) return ma[l][y][x];
    end
    return C_NONE;
  endfunction

  task automatic clear_model_a(input int first_layer, input int last_layer, input int n_addr);
    for (int a = 0; a < n_addr; a++)
      for (int l = first_layer; l <= last_layer; l++) ma[l][a / 8][a % 8] = C_NONE;
  endtask

  task automatic write_a(input int l, input int x, input int y, input logic [7:0] c);
    int n = 0;
    bus_a.wr_valid = 1'b1; bus_a.wr_layer = 1'(l);
    bus_a.wr_x = 3'(x); bus_a.wr_y = 3'(y); bus_a.wr_color = c;
    while (!bus_a.wr_ready && n < 200) begin tick(); n++; end
    if (n >= 200) check_val("wr_a_timeout", 64'(n), 64'd0);
    tick();
    bus_a.wr_valid = 1'b0;
    ma[l][y][x] = c;
  endtask

  task automatic read_a(input string tag, input int x, input int y);
    bus_a.rd_x = 3'(x); bus_a.rd_y = 3'(y);
    tick();
    check_val(tag, 64'(bus_a.rd_layers), 64'({ma[1][y][x], ma[0][y][x]}));
    check_val({tag, "_comp"}, 64'(bus_a.rd_color), 64'(comp_a(x, y)));
  endtask

  task automatic write_b(input int l, input int x, input int y, input logic [7:0] c);
    bus_b.wr_valid = 1'b1; bus_b.wr_layer = 2'(l);
    bus_b.wr_x = 4'(x); bus_b.wr_y = 3'(y); bus_b.wr_color = c;
    check_val("wr_b_ready", 64'(bus_b.wr_ready), 64'd1);
    tick();
    bus_b.wr_valid = 1'b0;
    if (l < 3 && x < 10 && y < 6) mb[l][y][x] = c;
  endtask

  task automatic read_b(input string tag, input int x, input int y);
    logic [23:0] exp_l;
    logic [7:0]  exp_c;
    exp_l = 24'h0;
    exp_c = C_NONE;
    bus_b.rd_x = 4'(x); bus_b.rd_y = 3'(y);
    if (x < 10 && y < 6) begin
      exp_l = {mb[2][y][x], mb[1][y][x], mb[0][y][x]};
      for (int l = 2; l >= 0; l--) if (exp_c == C_NONE) exp_c = mb[l][y][x];
    end
    tick();
    check_val(tag, 64'(bus_b.rd_layers), 64'(exp_l));
    check_val({tag, "_comp"}, 64'(bus_b.rd_color), 64'(exp_c));
  endtask

  task automatic count_sweep(input string tag);
    int n = 0;
    while (bus_a.busy && n < 200) begin tick(); n++; end
    check_val(tag, 64'(n), 64'd64);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, leaks, x, y, l;
    logic [15:0] old_v;

    bus_a.wr_valid = 1'b0; bus_a.wr_layer = 1'b0; bus_a.wr_x = 3'd0; bus_a.wr_y = 3'd0;
    bus_a.wr_color = C_NONE; bus_a.clr_valid = 1'b0; bus_a.clr_all = 1'b0; bus_a.clr_layer = 1'b0;
    bus_a.rd_x = 3'd0; bus_a.rd_y = 3'd0;
    bus_b.wr_valid = 1'b0; bus_b.wr_layer = 2'd0; bus_b.wr_x = 4'd0; bus_b.wr_y = 3'd0;
    bus_b.wr_color = C_NONE; bus_b.clr_valid = 1'b0; bus_b.clr_all = 1'b0; bus_b.clr_layer = 2'd0;
    bus_b.rd_x = 4'd0; bus_b.rd_y = 3'd0;
    for (int i = 0; i < 2; i++) for (int j = 0; j < 8; j++) for (int k = 0; k < 8; k++) ma[i][j][k] = C_NONE;
    for (int i = 0; i < 3; i++) for (int j = 0; j < 6; j++) for (int k = 0; k < 10; k++) mb[i][j][k] = C_NONE;

    // 1: reset values, power-on sweep length, empty canvas
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) tick();
    check_val("rst_wr_ready", 64'(bus_a.wr_ready), 64'd0);
    check_val("rst_clr_ready", 64'(bus_a.clr_ready), 64'd0);
    check_val("rst_busy", 64'(bus_a.busy), 64'd1);
    check_val("rst_rd_layers", 64'(bus_a.rd_layers), 64'd0);
    check_val("rst_rd_color", 64'(bus_a.rd_color), 64'd0);
    reset_n = 1'b1;
    count_sweep("t1_busy_cycles");
    check_val("t1_wr_ready", 64'(bus_a.wr_ready), 64'd1);
    check_val("t1_clr_ready", 64'(bus_a.clr_ready), 64'd1);
    check_val("t1_b_idle", 64'(bus_b.busy), 64'd0);
    read_a("t1_rd_00", 0, 0);
    read_a("t1_rd_77", 7, 7);

    // 2: single write on layer 0
    write_a(0, 3, 2, C_BLUE);
    read_a("t2_rd_32", 3, 2);
    read_a("t2_rd_23", 2, 3);

    // 3: layer 1 covers layer 0, then a layer-1-only clear
    write_a(1, 3, 2, C_RED);
    read_a("t3_top", 3, 2);
    bus_a.clr_valid = 1'b1; bus_a.clr_all = 1'b0; bus_a.clr_layer = 1'b1;
    tick();
    bus_a.clr_valid = 1'b0;
    count_sweep("t3_busy_cycles");
    clear_model_a(1, 1, 64);
    read_a("t3_after_clr", 3, 2);

    // 4: clear wins over a simultaneous write, held write lands after the sweep
    bus_a.rd_x = 3'd5; bus_a.rd_y = 3'd5;
    bus_a.clr_valid = 1'b1; bus_a.clr_all = 1'b1;
    bus_a.wr_valid = 1'b1; bus_a.wr_layer = 1'b0; bus_a.wr_x = 3'd5; bus_a.wr_y = 3'd5;
    bus_a.wr_color = C_GREEN;
    #1;
    check_val("t4_wr_ready_lo", 64'(bus_a.wr_ready), 64'd0);
    check_val("t4_clr_ready", 64'(bus_a.clr_ready), 64'd1);
    tick();
    bus_a.clr_valid = 1'b0;
    n = 0; leaks = 0;
    while (bus_a.busy && n < 200) begin
      if (bus_a.wr_ready) leaks++;
      tick(); n++;
      if (n == 1) check_val("t4_wr_blocked", 64'(bus_a.rd_layers), 64'd0);
    end
    check_val("t4_busy_cycles", 64'(n), 64'd64);
    check_val("t4_wr_ready_busy", 64'(leaks), 64'd0);
    check_val("t4_wr_ready_hi", 64'(bus_a.wr_ready), 64'd1);
    clear_model_a(0, 1, 64);
    tick();
    bus_a.wr_valid = 1'b0;
    ma[0][5][5] = C_GREEN;
    read_a("t4_held_write", 5, 5);

    // 5: read-first on a same-cycle read/write of one pixel
    old_v = {ma[1][2][3], ma[0][2][3]};
    bus_a.rd_x = 3'd3; bus_a.rd_y = 3'd2;
    bus_a.wr_valid = 1'b1; bus_a.wr_layer = 1'b0; bus_a.wr_x = 3'd3; bus_a.wr_y = 3'd2;
    bus_a.wr_color = C_RED;
    tick();
    bus_a.wr_valid = 1'b0;
    check_val("t5_old", 64'(bus_a.rd_layers), 64'(old_v));
    ma[0][2][3] = C_RED;
    tick();
    check_val("t5_new", 64'(bus_a.rd_layers), 64'({ma[1][2][3], ma[0][2][3]}));

    // random writes/reads against the model
    for (int i = 0; i < 40; i++) begin
      l = $urandom_range(1, 0); x = $urandom_range(7, 0); y = $urandom_range(7, 0);
      write_a(l, x, y, rand_color());
      read_a("rnd_a_hit", x, y);
      read_a("rnd_a_any", $urandom_range(7, 0), $urandom_range(7, 0));
    end

    // 6: reset in the middle of a layer-0 sweep
    write_a(1, 1, 1, C_RED);
    bus_a.rd_x = 3'd1; bus_a.rd_y = 3'd1;
    bus_a.clr_valid = 1'b1; bus_a.clr_all = 1'b0; bus_a.clr_layer = 1'b0;
    tick();
    bus_a.clr_valid = 1'b0;
    repeat (30) tick();
    clear_model_a(0, 0, 30);
    check_val("t6_mid_read", 64'(bus_a.rd_layers), 64'({ma[1][1][1], ma[0][1][1]}));
    reset_n = 1'b0;
    #1;
    check_val("t6_rst_wr_ready", 64'(bus_a.wr_ready), 64'd0);
    check_val("t6_rst_clr_ready", 64'(bus_a.clr_ready), 64'd0);
    check_val("t6_rst_busy", 64'(bus_a.busy), 64'd1);
    check_val("t6_rst_rd_layers", 64'(bus_a.rd_layers), 64'd0);
    check_val("t6_rst_rd_color", 64'(bus_a.rd_color), 64'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    count_sweep("t6_busy_cycles");
    clear_model_a(0, 1, 64);
    for (int a = 0; a < 64; a++) read_a("t6_all_clear", a % 8, a / 8);

    // out-of-range handling on the wider-bus instance
    write_b(1, 2, 1, C_RED);
    write_b(0, 12, 0, C_BLUE);
    write_b(3, 4, 4, C_GREEN);
    write_b(2, 9, 6, C_GREEN);
    read_b("b_alias", 2, 1);
    read_b("b_oor_x", 12, 0);
    read_b("b_oor_y", 9, 6);
    read_b("b_oor_layer", 4, 4);
    for (int i = 0; i < 60; i++) begin
      l = $urandom_range(3, 0); x = $urandom_range(11, 0); y = $urandom_range(6, 0);
      write_b(l, x, y, rand_color());
      read_b("rnd_b_hit", x, y);
      read_b("rnd_b_any", $urandom_range(15, 0), $urandom_range(7, 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
